// File: rtl/uart_rx_if.sv
// uart_rx_if: serial-side and result-side signals of the UART receiver.
//   tick          oversampling strobe, 1-clk pulse, 16 per bit
//   rx            serial line, asynchronous, idle high
//   data          last received word, held until the next frame completes
//   rx_done_tick  1-clk pulse when data is updated
//   frame_err     stop bit sampled low on the last frame
//   parity_err    parity mismatch on the last frame (UART_RX_PARITY_EN only)
// Modports: slave = receiver side, master = driver/consumer side.
// Optional feature macro: UART_RX_PARITY_EN.
interface uart_rx_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 tick;
  logic                 rx;
  logic [DATA_BITS-1:0] data;
  logic                 rx_done_tick;
  logic                 frame_err;
`ifdef UART_RX_PARITY_EN
  logic                 parity_err;

  modport slave  (input  tick, rx, output data, rx_done_tick, frame_err, parity_err);
  modport master (output tick, rx, input  data, rx_done_tick, frame_err, parity_err);
`else
  modport slave  (input  tick, rx, output data, rx_done_tick, frame_err);
  modport master (output tick, rx, input  data, rx_done_tick, frame_err);
`endif
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampling UART receiver. Deserialises an LSB-first frame
// (1 start, DATA_BITS data, optional even parity, 1 stop) from bus.rx and
// presents the word on bus.data with a one-clock bus.rx_done_tick pulse.
// Ports:
//   i_clk   system clock (single domain)
//   reset   synchronous, active-high
//   bus     uart_rx_if.slave (tick, rx in; data, rx_done_tick, frame_err,
//           parity_err out)
// Parameters: DATA_BITS (5..8), SB_TICK (ticks spent in the stop bit).
// Optional feature macro: UART_RX_PARITY_EN adds the PARITY state and the
// parity_err output.
module uart_rx #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned SB_TICK   = 16
) (
  input logic      i_clk,
  input logic      reset,
  uart_rx_if.slave bus
);

  localparam int unsigned NW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

  localparam logic [3:0]    S_MID  = 4'd7;
  localparam logic [3:0]    S_LAST = 4'd15;
  localparam logic [3:0]    S_STOP = 4'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);

  logic [1:0]           sync_q;
  logic                 rx_s;
  logic [2:0]           state;
  logic [3:0]           s_cnt;
  logic [NW-1:0]        n_cnt;
  logic [DATA_BITS-1:0] b;
  logic [DATA_BITS-1:0] data_q;
  logic                 done_q;
  logic                 ferr_q;
`ifdef UART_RX_PARITY_EN
  logic                 p;
  logic                 perr_q;
`endif

  assign rx_s = sync_q[1];

  always_ff @(posedge i_clk) begin
    if (reset) begin
      sync_q <= 2'b11;
      state  <= IDLE;
      s_cnt  <= '0;
      n_cnt  <= '0;
      b      <= '0;
      data_q <= '0;
      done_q <= 1'b0;
      ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      p      <= 1'b0;
      perr_q <= 1'b0;
`endif
    end else begin
      sync_q <= {sync_q[0], bus.rx};
      done_q <= 1'b0;
      case (state)
        // Leaving IDLE is edge-driven; no tick needed.
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            s_cnt <= '0;
          end
        end
        // Mid start bit: still low means a real frame, otherwise a glitch.
        START: begin
          if (bus.tick) begin
            if (s_cnt == S_MID) begin
              s_cnt <= '0;
              if (!rx_s) begin
                state <= DATA;
                n_cnt <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              s_cnt <= s_cnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (bus.tick) begin
            if (s_cnt == S_LAST) begin
              s_cnt <= '0;
              b     <= {rx_s, b[DATA_BITS-1:1]};
              if (n_cnt == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                n_cnt <= n_cnt + NW'(1);
              end
            end else begin
              s_cnt <= s_cnt + 4'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (bus.tick) begin
            if (s_cnt == S_LAST) begin
              s_cnt <= '0;
              p     <= rx_s;
              state <= STOP;
            end else begin
              s_cnt <= s_cnt + 4'd1;
            end
          end
        end
`endif
        STOP: begin
          if (bus.tick) begin
            if (s_cnt == S_STOP) begin
              s_cnt  <= '0;
              data_q <= b;
              ferr_q <= ~rx_s;
`ifdef UART_RX_PARITY_EN
              perr_q <= ^{b, p};
`endif
              done_q <= 1'b1;
              state  <= IDLE;
            end else begin
              s_cnt <= s_cnt + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.data         = data_q;
  assign bus.rx_done_tick = done_q;
  assign bus.frame_err    = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err   = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx. Frames are described as a list
// of line levels (one entry per bit); a reference model decodes that list to
// the expected word and error flags. Table vectors, hand-written corner
// sequences and random frames are compared against DUT results collected by
// a done-pulse monitor.
module tb_uart_rx;
  localparam int unsigned DB = 8;
`ifdef UART_RX_PARITY_EN
  localparam bit PB = 1'b1;
`else
  localparam bit PB = 1'b0;
`endif
  localparam int unsigned FRAME_T = (2 + DB + 32'(PB)) * 16;
  // Ticks from a start edge to the done pulse of a frame.
  localparam int unsigned DONE_T  = FRAME_T - 8;

  logic clk = 1'b0;
  logic reset;

  uart_rx_if #(.DATA_BITS(DB)) bus ();

  uart_rx #(.DATA_BITS(DB), .SB_TICK(16)) dut (
    .i_clk (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Stand-in for baud_rate_gen with divisor 9: one tick every 9 clocks.
  int unsigned div_cnt = 0;
  logic        tick_r  = 1'b0;
  always @(posedge clk) begin
    if (div_cnt == 8) begin
      div_cnt <= 0;
      tick_r  <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1;
      tick_r  <= 1'b0;
    end
  end
  assign bus.tick = tick_r;

  typedef struct {
    logic [DB-1:0] data;
    logic          ferr;
    logic          perr;
  } rx_t;

  rx_t got_q[$];
  rx_t mon_r;

  always @(negedge clk) begin
    if (bus.rx_done_tick === 1'b1) begin
      mon_r.data = bus.data;
      mon_r.ferr = bus.frame_err;
`ifdef UART_RX_PARITY_EN
      mon_r.perr = bus.parity_err;
`else
      mon_r.perr = 1'b0;
`endif
      got_q.push_back(mon_r);
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Returns at the negedge just before a tick is consumed.
  task automatic wait_ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      while (tick_r !== 1'b1) @(negedge clk);
    end
  endtask

  task automatic build(input logic [DB-1:0] din, input logic par, input logic stop,
                       output bit fb[$]);
    fb.delete();
    fb.push_back(1'b0);
    for (int i = 0; i < DB; i++) fb.push_back(din[i]);
    if (PB) fb.push_back(par);
    fb.push_back(stop);
  endtask

  // A low stop bit is released early: the receiver restarts from IDLE on the
  // low line and must see it high again at its start-bit check.
  task automatic send_bits(input bit fb[$]);
    for (int i = 0; i < fb.size(); i++) begin
      bus.rx = fb[i];
      wait_ticks((i == fb.size() - 1 && !fb[i]) ? 12 : 16);
    end
    bus.rx = 1'b1;
  endtask

  function automatic rx_t model(input bit fb[$]);
    rx_t r;
    logic x;
    for (int i = 0; i < DB; i++) r.data[i] = fb[1 + i];
    x = 1'b0;
    for (int i = 1; i <= DB + 32'(PB); i++) x ^= fb[i];
    r.perr = PB ? x : 1'b0;
    r.ferr = !fb[fb.size() - 1];
    return r;
  endfunction

  task automatic check_frame(input string name, input rx_t exp);
    rx_t g;
    check({name, " pulses"}, 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) begin
      g = got_q.pop_front();
      check({name, " data"}, 32'(g.data), 32'(exp.data));
      check({name, " ferr"}, 32'(g.ferr), 32'(exp.ferr));
`ifdef UART_RX_PARITY_EN
      check({name, " perr"}, 32'(g.perr), 32'(exp.perr));
`endif
    end
    got_q.delete();
  endtask

  typedef struct {
    string         name;
    logic [DB-1:0] din;
    logic          par;
    logic          stop;
    logic [DB-1:0] exp_data;
    logic          exp_ferr;
    logic          exp_perr;
  } vec_t;

  vec_t vt[6];

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit   fb[$];
    bit   fb2[$];
    rx_t  exp;
    logic [DB-1:0] din;
    logic stop, par;

    vt[0] = '{"a5_good",     8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vt[1] = '{"3c_stop_low", 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0};
    vt[2] = '{"5a_clears",   8'h5A, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0};
    vt[3] = '{"07_par1",     8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
    vt[4] = '{"07_par0",     8'h07, 1'b0, 1'b1, 8'h07, 1'b0, 1'b1};
    vt[5] = '{"ff_good",     8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};

    reset  = 1'b1;
    bus.rx = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset data", 32'(bus.data), 32'h0);
    check("reset done", 32'(bus.rx_done_tick), 32'h0);
    check("reset ferr", 32'(bus.frame_err), 32'h0);
`ifdef UART_RX_PARITY_EN
    check("reset perr", 32'(bus.parity_err), 32'h0);
`endif
    wait_ticks(4);

    for (int i = 0; i < 6; i++) begin
      build(vt[i].din, vt[i].par, vt[i].stop, fb);
      send_bits(fb);
      exp.data = vt[i].exp_data;
      exp.ferr = vt[i].exp_ferr;
      exp.perr = vt[i].exp_perr;
      check_frame(vt[i].name, exp);
      wait_ticks(4);
    end

    // Short low glitch: rejected at the start-bit check.
    bus.rx = 1'b0;
    wait_ticks(4);
    bus.rx = 1'b1;
    wait_ticks(24);
    check("glitch pulses", 32'(got_q.size()), 32'd0);
    check("glitch data held", 32'(bus.data), 32'hFF);
    got_q.delete();

    // Reset during data bit 3 of 0x55.
    build(8'h55, 1'b0, 1'b1, fb);
    for (int i = 0; i < 4; i++) begin
      bus.rx = fb[i];
      wait_ticks(16);
    end
    bus.rx = fb[4];
    wait_ticks(8);
    reset  = 1'b1;
    bus.rx = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_ticks(40);
    check("midreset pulses", 32'(got_q.size()), 32'd0);
    check("midreset data", 32'(bus.data), 32'h0);
    got_q.delete();
    build(8'hC3, 1'b0, 1'b1, fb);
    send_bits(fb);
    check_frame("after_reset_c3", model(fb));
    wait_ticks(4);

    // Back-to-back 0x00 then 0xFF, no idle gap.
    build(8'h00, 1'b0, 1'b1, fb);
    build(8'hFF, 1'b0, 1'b1, fb2);
    send_bits({fb, fb2});
    check("b2b pulses", 32'(got_q.size()), 32'd2);
    if (got_q.size() == 2) begin
      check("b2b first data", 32'(got_q[0].data), 32'h00);
      check("b2b second data", 32'(got_q[1].data), 32'hFF);
      check("b2b second ferr", 32'(got_q[1].ferr), 32'h0);
    end
    check("b2b final data", 32'(bus.data), 32'hFF);
    got_q.delete();
    wait_ticks(4);

    // Break: line held low long enough for exactly two frames.
    bus.rx = 1'b0;
    wait_ticks(2 * DONE_T + 6);
    bus.rx = 1'b1;
    wait_ticks(40);
    check("break pulses", 32'(got_q.size()), 32'd2);
    while (got_q.size() > 0) begin
      exp = got_q.pop_front();
      check("break data", 32'(exp.data), 32'h0);
      check("break ferr", 32'(exp.ferr), 32'h1);
    end
    wait_ticks(4);

    for (int i = 0; i < 16; i++) begin
      din  = DB'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      par  = (^din) ^ ($urandom_range(0, 3) == 0);
      build(din, par, stop, fb);
      send_bits(fb);
      check_frame($sformatf("rand%0d", i), model(fb));
      wait_ticks(stop ? $urandom_range(0, 3) : 4 + $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
